// File: rtl/apb_reg_bank.sv
// APB3 slave register bank: NUM_REGS word registers at BASE_ADDR, per-register
// read-only status mapping, byte strobes and a programmable wait-state count.
module apb_reg_bank #(
    parameter int                        ADDR_WIDTH  = 10,
    parameter int                        DATA_WIDTH  = 32,
    parameter int                        NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR   = 10'd5,
    parameter logic [NUM_REGS-1:0]       RO_MASK     = {NUM_REGS{1'b0}},
    parameter int                        WAIT_STATES = 1
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                                 state, state_next;
    logic [3:0]                             cnt, cnt_next;
    logic                                   capture, commit;

    logic [ADDR_WIDTH-1:0]                  addr_q;
    logic                                   write_q;
    logic [DATA_WIDTH-1:0]                  wdata_q;
    logic [STRB_W-1:0]                      strb_q;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    status;

    logic [ADDR_WIDTH-1:0]                  x_addr;
    logic                                   x_write;
    logic [DATA_WIDTH-1:0]                  x_wdata;
    logic [STRB_W-1:0]                      x_strb;
    logic [ADDR_WIDTH:0]                    diff;
    logic                                   hit, ro;
    logic [IDX_W-1:0]                       idx;

    assign status = reg_in;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_next = IDLE;
                if (psel && !penable) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = 4'(WAIT_STATES);
                    end
                end
            end
            ACCESS: begin
                if (!(psel && penable)) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    commit     = 1'b1;
                    state_next = RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the transfer commits on the setup edge, so decode the live bus.
    always_comb begin
        x_addr  = capture ? paddr  : addr_q;
        x_write = capture ? pwrite : write_q;
        x_wdata = capture ? pwdata : wdata_q;
        x_strb  = capture ? pstrb  : strb_q;
        diff    = {1'b0, x_addr} - {1'b0, BASE_ADDR};
        hit     = !diff[ADDR_WIDTH] && (diff < (ADDR_WIDTH+1)'(NUM_REGS));
        idx     = diff[IDX_W-1:0];
        ro      = hit && RO_MASK[idx];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: the register array is reset because software expects zeroed control registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            regs     <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
        end else begin
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
            if (capture) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            if (commit) begin
                pready <= 1'b1;
                if (!hit || (x_write && ro)) begin
                    pslverr <= 1'b1;
                end else if (x_write) begin
                    wr_pulse[idx] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (x_strb[b]) regs[idx][b*8 +: 8] <= x_wdata[b*8 +: 8];
                    end
                end else begin
                    prdata <= ro ? status[idx] : regs[idx];
                end
            end
        end
    end

    // Read-only registers are never written, so their slices of reg_out stay zero.
    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (!RO_MASK[k]) reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
        end
    end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
Parametrised APB3 slave register bank, successor of the fixed three-register APB bridge. It provides NUM_REGS consecutive word registers with a configurable base address, data width and wait-state count. Each register is individually read-write or read-only; read-only registers return hardware status. It sits between the APB fabric and block-level control/status logic, all in the APB clock domain. CDC is done outside this block.

Parameters:
ADDR_WIDTH, 10, width of paddr (word address).
DATA_WIDTH, 32, register/bus width; multiple of 8, range 8..64.
NUM_REGS, 8, number of registers, 1..64; register k decodes at BASE_ADDR+k.
BASE_ADDR, 10'd5, word address of register 0.
RO_MASK, {NUM_REGS{1'b0}}, bit k=1 makes register k read-only (reads reg_in slice k).
WAIT_STATES, 1, access-phase wait cycles before pready, 0..15.

Ports:
pclk  input  1  APB clock, sole clock.
preset_n  input  1  asynchronous active-low reset.
paddr  input  ADDR_WIDTH  word address.
psel  input  1  slave select.
penable  input  1  access phase.
pwrite  input  1  1=write, 0=read.
pwdata  input  DATA_WIDTH  write data.
pstrb  input  DATA_WIDTH/8  byte write strobes.
pready  output  1  transfer complete.
prdata  output  DATA_WIDTH  read data, valid only while pready=1.
pslverr  output  1  error response, valid only while pready=1.
reg_in  input  NUM_REGS*DATA_WIDTH  status values for read-only registers, slice k = [k*DATA_WIDTH +: DATA_WIDTH].
reg_out  output  NUM_REGS*DATA_WIDTH  current contents of read-write registers (RO slices drive 0).
wr_pulse  output  NUM_REGS  one-cycle strobe per register on a committed write.

Behaviour:
- Reset (preset_n=0, asynchronous): FSM=IDLE; pready=0, pslverr=0, prdata=0, reg_out=0, wr_pulse=0, wait counter=0.
- FSM states are IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: psel=1 and penable=0 (setup) -> capture paddr/pwrite/pwdata/pstrb, load counter=WAIT_STATES, go to ACCESS. penable=1 without a prior setup is ignored.
- ACCESS: each cycle with psel=1 and penable=1, decrement the counter. When the counter is 0, go to RESP and assert pready next cycle.
- Resulting timing: first access cycle T1, pready=1 during cycle T1+WAIT_STATES, for exactly one cycle.
- Abort: psel=0 or penable=0 while in ACCESS -> return to IDLE, no write, no response.
- Decode: hit if BASE_ADDR <= addr < BASE_ADDR+NUM_REGS, index = addr-BASE_ADDR. Compute the subtraction at ADDR_WIDTH+1 bits; no wrap past 2^ADDR_WIDTH.
- Read hit: prdata = register k, or reg_in slice k if RO_MASK[k]. The RO value is the one sampled on the edge that raises pready. pslverr=0.
- Write hit, RW register: byte i updates iff pstrb[i]=1. The commit happens on the edge that raises pready. wr_pulse[k]=1 for that same pready cycle, even if pstrb=0. pslverr=0.
- Write to RO register: no state change, wr_pulse stays 0, pslverr=1.
- Miss (read or write): pslverr=1, prdata=0, no state change.
- RESP: pready=1 for one cycle, then the FSM returns to IDLE and pready, pslverr, prdata and wr_pulse return to 0.
  - A new setup in the same cycle as pready is accepted (back-to-back transfers).
- Reset asserted mid-transfer: immediate return to reset values; the pending write is discarded.

Test Plan:
1. Defaults, write addr 5 data 32'hDEADBEEF pstrb 4'hF, then read addr 5 -> pready in T1+1; reg_out[31:0]=DEADBEEF; wr_pulse[0] one cycle; read prdata=DEADBEEF, pslverr=0.
2. Reg 1 = 32'h11223344, write addr 6 data 32'hAABBCCDD pstrb 4'b0101 -> reg 1 = 32'h11BB33DD.
3. RO_MASK=8'h04, reg_in slice 2 = 32'h0000_00A5 -> read addr 7 gives A5, pslverr=0. Write addr 7 gives pslverr=1, slice unchanged, wr_pulse=0.
4. Read addr 4 and addr 13 (misses) -> pready=1, pslverr=1, prdata=0. Write addr 13 -> no reg_out change.
5. WAIT_STATES=0, then 3 -> pready in T1 and T1+3 respectively. Drop penable at T1+1 with WAIT_STATES=3 -> no pready, no write, FSM in IDLE.
6. Drive preset_n=0 during ACCESS of a write -> all outputs 0 immediately. After release, a read of the target returns 0.
